// File: rtl/scan_pkg.sv
// Shared types and constants for the row-scan sequencer.
package scan_pkg;
  localparam int CNT_W = 8;
  localparam int NROWS = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2,
    S_HOLD  = 2'd3
  } scan_state_t;
endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter: load N-1, done is high on the cycle the count reaches zero.
module scan_timer
  import scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/scan_seq.sv
// Row-scan sequencer: blanks, drives each of 16 rows, samples sense at the end of
// each drive window and hands the captured frame to a consumer.
module scan_seq
  import scan_pkg::*;
#(
  parameter int DWELL     = 4,
  parameter int BLANK_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              sense,
  input  logic              frame_ready,
  output logic [3:0]        sel,
  output logic              blank,
  output logic [NROWS-1:0]  frame,
  output logic              frame_valid,
  output logic              busy,
  output scan_state_t       dbg_state
);

  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYC - 1);
  localparam logic [3:0]       LAST_ROW = 4'(NROWS - 1);

  scan_state_t      state, state_n;
  logic [3:0]       sel_n;
  logic [NROWS-1:0] acc, acc_n, frame_n;
  logic             fv_n, stop_pending, sp_n;
  logic             tload, tdone, load_frame;
  logic [CNT_W-1:0] tval;

  scan_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tload),
    .load_val (tval),
    .done     (tdone)
  );

  // Handshake: a frame transfers on any cycle where frame_valid and frame_ready are
  // both 1; frame is held stable while valid is high and ready is low.
  always_comb begin
    state_n    = state;
    sel_n      = sel;
    acc_n      = acc;
    frame_n    = frame;
    fv_n       = frame_valid;
    sp_n       = stop_pending | (stop && state != S_IDLE);
    tload      = 1'b0;
    tval       = BLANK_LD;
    load_frame = 1'b0;

    if (frame_valid && frame_ready) fv_n = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          state_n = S_BLANK;
          sel_n   = '0;
          acc_n   = '0;
          tload   = 1'b1;
          tval    = BLANK_LD;
        end
      end
      S_BLANK: begin
        if (tdone) begin
          state_n = S_DRIVE;
          tload   = 1'b1;
          tval    = DWELL_LD;
        end
      end
      S_DRIVE: begin
        if (tdone) begin
          acc_n[sel] = sense;
          if (sel != LAST_ROW) begin
            sel_n   = sel + 4'd1;
            state_n = S_BLANK;
            tload   = 1'b1;
            tval    = BLANK_LD;
          end else if (!frame_valid || frame_ready) begin
            load_frame = 1'b1;
          end else begin
            state_n = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (frame_ready) load_frame = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    // Frame hand-off shared by the end of row 15 and the exit from HOLD.
    if (load_frame) begin
      frame_n = acc_n;
      fv_n    = 1'b1;
      acc_n   = '0;
      sel_n   = '0;
      if (sp_n) begin
        state_n = S_IDLE;
        sp_n    = 1'b0;
      end else begin
        state_n = S_BLANK;
        tload   = 1'b1;
        tval    = BLANK_LD;
      end
    end

    if (state_n == S_IDLE) sp_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      sel          <= '0;
      blank        <= 1'b1;
      frame        <= '0;
      frame_valid  <= 1'b0;
      busy         <= 1'b0;
      acc          <= '0;
      stop_pending <= 1'b0;
    end else begin
      state        <= state_n;
      sel          <= sel_n;
      blank        <= (state_n != S_DRIVE);
      frame        <= frame_n;
      frame_valid  <= fv_n;
      busy         <= (state_n != S_IDLE);
      acc          <= acc_n;
      stop_pending <= sp_n;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_scan_seq.sv
// Directed bench for scan_seq (DWELL=4, BLANK_CYC=2): 6-cycle rows, 96-cycle frames.
module tb_scan_seq;
  import scan_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, stop, sense, frame_ready;
  logic [3:0]  sel;
  logic        blank, frame_valid, busy;
  logic [15:0] frame;
  scan_state_t dbg_state;

  int cyc;
  int checks;
  int failures;
  int s0;

  scan_seq #(.DWELL(4), .BLANK_CYC(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .sense       (sense),
    .frame_ready (frame_ready),
    .sel         (sel),
    .blank       (blank),
    .frame       (frame),
    .frame_valid (frame_valid),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; sense = 1'b0; frame_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_sel",   32'(sel), 32'd0);
    check("rst_blank", 32'(blank), 32'd1);
    check("rst_frame", 32'(frame), 32'h0);
    check("rst_fv",    32'(frame_valid), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));

    // Frame 1: sense only on last drive cycle of row 5 (cycle 36)
    cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc <= 96) begin
      sense = (cyc == 36);
      if (cyc == 1) begin
        check("f1_blank1", 32'(blank), 32'd1);
        check("f1_busy1",  32'(busy), 32'd1);
        check("f1_sel1",   32'(sel), 32'd0);
      end
      if (cyc == 3)  check("f1_drive3", 32'(blank), 32'd0);
      if (cyc == 7)  check("f1_sel7",   32'(sel), 32'd1);
      if (cyc == 36) check("f1_sel36",  32'(sel), 32'd5);
      if (cyc == 96) check("f1_fv96",   32'(frame_valid), 32'd0);
      tick();
    end
    sense = 1'b0;
    check("f1_fv97",    32'(frame_valid), 32'd1);
    check("f1_frame97", 32'(frame), 32'h0020);
    check("f1_sel97",   32'(sel), 32'd0);
    check("f1_blank97", 32'(blank), 32'd1);

    // Frame 2: sense high on drive cycles 1-3 only -> all zeros
    while (cyc <= 192) begin
      sense = (((cyc - 97) % 6) >= 2) && (((cyc - 97) % 6) <= 4);
      if (cyc == 98) check("f2_fvclr", 32'(frame_valid), 32'd0);
      tick();
    end
    sense = 1'b0;
    check("f2_fv",    32'(frame_valid), 32'd1);
    check("f2_frame", 32'(frame), 32'h0000);

    // Frame 3 with backpressure: rows 0 and 15 set, ends in HOLD
    frame_ready = 1'b0;
    while (cyc <= 288) begin
      sense = (cyc == 198) || (cyc == 288);
      tick();
    end
    sense = 1'b0;
    while (cyc < 292) begin
      check("hold_state", 32'(dbg_state), 32'(S_HOLD));
      check("hold_blank", 32'(blank), 32'd1);
      check("hold_sel",   32'(sel), 32'd15);
      check("hold_frame", 32'(frame), 32'h0000);
      check("hold_fv",    32'(frame_valid), 32'd1);
      tick();
    end
    frame_ready = 1'b1;
    tick();
    check("rel_frame", 32'(frame), 32'h8001);
    check("rel_fv",    32'(frame_valid), 32'd1);
    check("rel_sel",   32'(sel), 32'd0);
    check("rel_state", 32'(dbg_state), 32'(S_BLANK));
    tick(); tick();
    check("rel_drive", 32'(blank), 32'd0);

    // Frame 4: stop pulsed during row 7, row 9 sensed, then IDLE
    while (cyc <= 388) begin
      stop  = (cyc == 338);
      sense = (cyc == 352);
      if (cyc == 338) check("stop_sel", 32'(sel), 32'd7);
      if (cyc == 370) check("stop_busy_mid", 32'(busy), 32'd1);
      tick();
    end
    stop = 1'b0; sense = 1'b0;
    check("stop_fv",    32'(frame_valid), 32'd1);
    check("stop_frame", 32'(frame), 32'h0200);
    check("stop_busy",  32'(busy), 32'd0);
    check("stop_blank", 32'(blank), 32'd1);
    check("stop_state", 32'(dbg_state), 32'(S_IDLE));
    tick();
    check("stop_fvclr", 32'(frame_valid), 32'd0);

    // start and stop together in IDLE: stop wins
    start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("ss_busy",  32'(busy), 32'd0);
      check("ss_blank", 32'(blank), 32'd1);
    end
    start = 1'b0; stop = 1'b0;

    // Reset during DRIVE of row 9
    s0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    sense = 1'b1;
    while (cyc < s0 + 58) tick();
    check("mid_sel",   32'(sel), 32'd9);
    check("mid_drive", 32'(blank), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0; sense = 1'b0;
    check("mrst_sel",   32'(sel), 32'd0);
    check("mrst_blank", 32'(blank), 32'd1);
    check("mrst_fv",    32'(frame_valid), 32'd0);
    check("mrst_frame", 32'(frame), 32'h0000);
    check("mrst_busy",  32'(busy), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_blank", 32'(blank), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
